// File: rtl/loop_sequencer.sv
// Q-regulation loop sequencer: settles, measures and updates until the loop
// converges, goes unstable, runs out of iterations or a measurement times out.
module loop_sequencer #(
    parameter int BUS_WIDTH     = 10,
    parameter int TOL           = 1,
    parameter int CONV_COUNT    = 3,
    parameter int MAX_ITER      = 32,
    parameter int SETTLE_CYCLES = 16,
    parameter int MEAS_TIMEOUT  = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [BUS_WIDTH-1:0] q_desired_in,
    input  logic                 ready,
    input  logic [BUS_WIDTH-1:0] q_measured,
    input  logic                 went_unstable,
    output logic                 start,
    output logic                 enable,
    output logic [BUS_WIDTH-1:0] q_target,
    output logic                 busy,
    output logic [2:0]           status,
    output logic [7:0]           iter_count
);

    typedef enum logic [2:0] {
        IDLE, SETTLE, MEASURE, UPDATE, CONVERGED, LIMITED, FAULT
    } state_t;

    localparam logic [2:0] ST_NONE      = 3'b000;
    localparam logic [2:0] ST_CONVERGED = 3'b001;
    localparam logic [2:0] ST_LIMITED   = 3'b010;
    localparam logic [2:0] ST_FAULT_TMO = 3'b101;
    localparam logic [2:0] ST_FAULT_ITR = 3'b110;

    localparam logic [BUS_WIDTH:0] TOL_V       = (BUS_WIDTH+1)'(TOL);
    localparam logic [7:0]         CONV_MAX    = 8'(CONV_COUNT);
    localparam logic [7:0]         ITER_LAST   = 8'(MAX_ITER - 1);
    localparam logic [15:0]        SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0]        TMO_LAST    = 16'(MEAS_TIMEOUT - 1);

    state_t                state;
    logic [15:0]           settle_cnt;
    logic [15:0]           tmo_cnt;
    logic [7:0]            conv_cnt;
    logic                  unstable;
    logic signed [BUS_WIDTH:0] diff;
    logic [BUS_WIDTH:0]    abs_diff;

    // One extra bit keeps the error magnitude exact for any pair of Q values.
    always_comb begin
        diff     = $signed({1'b0, q_measured}) - $signed({1'b0, q_target});
        abs_diff = diff[BUS_WIDTH] ? -diff : diff;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            start      <= 1'b0;
            enable     <= 1'b0;
            busy       <= 1'b0;
            q_target   <= '0;
            status     <= ST_NONE;
            iter_count <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            conv_cnt   <= '0;
            unstable   <= 1'b0;
        end else begin
            start <= 1'b0;
            if (!run) begin
                state      <= IDLE;
                enable     <= 1'b0;
                busy       <= 1'b0;
                status     <= ST_NONE;
                iter_count <= '0;
                settle_cnt <= '0;
                tmo_cnt    <= '0;
                conv_cnt   <= '0;
                unstable   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        q_target   <= q_desired_in;
                        iter_count <= '0;
                        conv_cnt   <= '0;
                        status     <= ST_NONE;
                        settle_cnt <= '0;
                        enable     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state   <= MEASURE;
                            start   <= 1'b1;
                            tmo_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 16'd1;
                        end
                    end
                    MEASURE: begin
                        if (ready) begin
                            if (abs_diff <= TOL_V) begin
                                if (conv_cnt != CONV_MAX)
                                    conv_cnt <= conv_cnt + 8'd1;
                            end else begin
                                conv_cnt <= '0;
                            end
                            unstable <= went_unstable;
                            state    <= UPDATE;
                        end else if (tmo_cnt == TMO_LAST) begin
                            state  <= FAULT;
                            status <= ST_FAULT_TMO;
                            enable <= 1'b0;
                            busy   <= 1'b0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                    UPDATE: begin
                        if (iter_count != 8'hFF)
                            iter_count <= iter_count + 8'd1;
                        if (unstable) begin
                            state  <= LIMITED;
                            status <= ST_LIMITED;
                            enable <= 1'b0;
                            busy   <= 1'b0;
                        end else if (conv_cnt == CONV_MAX) begin
                            state  <= CONVERGED;
                            status <= ST_CONVERGED;
                            enable <= 1'b0;
                            busy   <= 1'b0;
                        end else if (iter_count == ITER_LAST) begin
                            state  <= FAULT;
                            status <= ST_FAULT_ITR;
                            enable <= 1'b0;
                            busy   <= 1'b0;
                        end else begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                        end
                    end
                    // A new request relaunches from a finished loop; a fault must be cleared by dropping run.
                    CONVERGED, LIMITED: begin
                        if (q_desired_in != q_target) begin
                            q_target   <= q_desired_in;
                            iter_count <= '0;
                            conv_cnt   <= '0;
                            status     <= ST_NONE;
                            settle_cnt <= '0;
                            enable     <= 1'b1;
                            busy       <= 1'b1;
                            state      <= SETTLE;
                        end
                    end
                    FAULT: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer: start timing is checked by a
// scoreboard of expected start cycles, outcomes inline in each scenario task.
module tb_loop_sequencer;

    localparam int W  = 10;
    localparam int S  = 16;
    localparam int MT = 1023;
    localparam int MI = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         run = 1'b0;
    logic         ready = 1'b0;
    logic         went_unstable = 1'b0;
    logic [W-1:0] q_desired_in = '0;
    logic [W-1:0] q_measured = '0;
    logic         start, enable, busy;
    logic [W-1:0] q_target;
    logic [2:0]   status;
    logic [7:0]   iter_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_start[$];

    loop_sequencer #(
        .BUS_WIDTH(W), .TOL(1), .CONV_COUNT(3), .MAX_ITER(MI),
        .SETTLE_CYCLES(S), .MEAS_TIMEOUT(MT)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .q_desired_in(q_desired_in),
        .ready(ready), .q_measured(q_measured), .went_unstable(went_unstable),
        .start(start), .enable(enable), .q_target(q_target), .busy(busy),
        .status(status), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every start must match the next expected start cycle in the scoreboard.
    always @(negedge clk) begin
        if (start === 1'b1) begin
            checks++;
            if (exp_start.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_start at cycle %0d", cyc);
            end else begin
                int e;
                e = exp_start.pop_front();
                if (cyc != e) begin
                    errors++;
                    $display("[TB] FAIL start_cycle got %0d expected %0d", cyc, e);
                end
            end
        end
    end

    task automatic wait_start(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (start === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic launch(input logic [W-1:0] q, input bit expect_start);
        q_desired_in = q;
        run = 1'b1;
        if (expect_start) exp_start.push_back(cyc + S + 1);
    endtask

    task automatic pulse_ready(input logic [W-1:0] q, input logic unst, input bit expect_next);
        if (expect_next) exp_start.push_back(cyc + S + 2);
        ready = 1'b1;
        q_measured = q;
        went_unstable = unst;
        @(negedge clk);
        ready = 1'b0;
        went_unstable = 1'b0;
    endtask

    task automatic abort_run();
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit seen;
        repeat (2) @(negedge clk);
        checks++;
        if ({start, enable, busy, q_target, status, iter_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b expected 0",
                     {start, enable, busy, q_target, status, iter_count});
        end
        rst = 1'b1;
        @(negedge clk);
        launch(10'd500, 1'b1);
        wait_start(S + 5, seen);
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL reset_launch_start got none expected start"); end
        rst = 1'b0;
        #1;
        checks++;
        if ({start, enable, busy, q_target, status, iter_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_measure got %b expected 0",
                     {start, enable, busy, q_target, status, iter_count});
        end
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_ready(10'd500, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if ({enable, busy, status, iter_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ready_ignored got %b expected 0", {enable, busy, status, iter_count});
        end
    endtask

    task automatic test_convergence();
        bit seen;
        logic [W-1:0] qs [4];
        qs[0] = 10'd480; qs[1] = 10'd499; qs[2] = 10'd501; qs[3] = 10'd500;
        launch(10'd500, 1'b1);
        wait_start(S + 5, seen);
        checks++;
        if (!seen || enable !== 1'b1 || busy !== 1'b1 || q_target !== 10'd500) begin
            errors++;
            $display("[TB] FAIL conv_launch seen=%0d en=%b busy=%b qt=%0d expected 1/1/1/500",
                     seen, enable, busy, q_target);
        end
        for (int i = 0; i < 4; i++) begin
            pulse_ready(qs[i], 1'b0, i < 3);
            if (i < 3) begin
                wait_start(S + 6, seen);
                checks++;
                if (!seen) begin errors++; $display("[TB] FAIL conv_iter%0d_start got none expected start", i); end
            end
        end
        @(negedge clk);
        checks++;
        if (status !== 3'b001 || iter_count !== 8'd4 || enable !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL conv_result status=%b iter=%0d en=%b busy=%b expected 001/4/0/0",
                     status, iter_count, enable, busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (status !== 3'b001 || iter_count !== 8'd4) begin
            errors++;
            $display("[TB] FAIL conv_hold status=%b iter=%0d expected 001/4", status, iter_count);
        end
        abort_run();
    endtask

    task automatic test_timeout();
        bit seen;
        launch(10'd500, 1'b1);
        wait_start(S + 5, seen);
        repeat (MT - 1) @(negedge clk);
        checks++;
        if (!seen || busy !== 1'b1 || status !== 3'b000) begin
            errors++;
            $display("[TB] FAIL tmo_before seen=%0d busy=%b status=%b expected 1/1/000", seen, busy, status);
        end
        @(negedge clk);
        checks++;
        if (status !== 3'b101 || busy !== 1'b0 || enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tmo_fault status=%b busy=%b en=%b expected 101/0/0", status, busy, enable);
        end
        abort_run();
        launch(10'd500, 1'b1);
        wait_start(S + 5, seen);
        repeat (MT - 1) @(negedge clk);
        pulse_ready(10'd480, 1'b0, 1'b1);
        checks++;
        if (!seen || status !== 3'b000 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tmo_ready_wins seen=%0d status=%b busy=%b expected 1/000/1", seen, status, busy);
        end
        wait_start(S + 6, seen);
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL tmo_restart got none expected start"); end
        abort_run();
    endtask

    task automatic test_max_iter();
        bit seen;
        int missed = 0;
        launch(10'd500, 1'b1);
        for (int i = 0; i < MI; i++) begin
            wait_start(S + 6, seen);
            if (!seen) missed++;
            pulse_ready(10'd0, 1'b0, i < MI - 1);
        end
        checks++;
        if (missed != 0) begin errors++; $display("[TB] FAIL iter_starts missed %0d expected 0", missed); end
        @(negedge clk);
        checks++;
        if (status !== 3'b110 || iter_count !== 8'd32 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL iter_fault status=%b iter=%0d busy=%b expected 110/32/0", status, iter_count, busy);
        end
        abort_run();
    endtask

    task automatic test_instability();
        bit seen, seen2;
        launch(10'd500, 1'b1);
        wait_start(S + 5, seen);
        pulse_ready(10'd480, 1'b0, 1'b1);
        wait_start(S + 6, seen2);
        pulse_ready(10'd480, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (!seen || !seen2 || status !== 3'b010 || iter_count !== 8'd2 || enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL unst_limited status=%b iter=%0d en=%b expected 010/2/0", status, iter_count, enable);
        end
        q_desired_in = 10'd600;
        exp_start.push_back(cyc + S + 1);
        @(negedge clk);
        checks++;
        if (q_target !== 10'd600 || status !== 3'b000 || busy !== 1'b1 || iter_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL unst_retarget qt=%0d status=%b busy=%b iter=%0d expected 600/000/1/0",
                     q_target, status, busy, iter_count);
        end
        wait_start(S + 5, seen);
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL unst_retarget_start got none expected start"); end
        abort_run();
    endtask

    task automatic test_abort();
        bit seen;
        launch(10'd300, 1'b0);
        repeat (5) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || enable !== 1'b0 || status !== 3'b000) begin
            errors++;
            $display("[TB] FAIL abort_settle busy=%b en=%b status=%b expected 0/0/000", busy, enable, status);
        end
        repeat (S + 5) @(negedge clk);
        launch(10'd300, 1'b1);
        wait_start(S + 5, seen);
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (!seen || busy !== 1'b0 || enable !== 1'b0 || start !== 1'b0 || status !== 3'b000) begin
            errors++;
            $display("[TB] FAIL abort_measure busy=%b en=%b start=%b status=%b expected 0/0/0/000",
                     busy, enable, start, status);
        end
        pulse_ready(10'd300, 1'b0, 1'b0);
        repeat (S + 5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || iter_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL abort_ready_ignored busy=%b iter=%0d expected 0/0", busy, iter_count);
        end
    endtask

    initial begin
        test_reset();
        test_convergence();
        test_timeout();
        test_max_iter();
        test_instability();
        test_abort();
        checks++;
        if (exp_start.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_starts got %0d expected 0", exp_start.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
